// File: rtl/alu16_pkg.sv
// Opcode encodings for the alu16 execution unit (instruction bits [15:12]).
package alu16_pkg;

    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_PASSB = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_SHL   = 4'h4;
    localparam logic [3:0] OP_SHR   = 4'h5;
    localparam logic [3:0] OP_ASR   = 4'h6;
    localparam logic [3:0] OP_ROL   = 4'h7;
    localparam logic [3:0] OP_SUB   = 4'h8;
    localparam logic [3:0] OP_ADD   = 4'h9;
    localparam logic [3:0] OP_CMP   = 4'hA;
    localparam logic [3:0] OP_NOT   = 4'hB;
    localparam logic [3:0] OP_AND   = 4'hC;
    localparam logic [3:0] OP_OR    = 4'hD;
    localparam logic [3:0] OP_XOR   = 4'hE;
    localparam logic [3:0] OP_ADC   = 4'hF;

endpackage

// File: rtl/alu16_addsub.sv
// Shared adder/subtractor: sub=0 gives a+b+cin with carry out,
// sub=1 gives a-b-cin with borrow out; ovf is signed overflow.
module alu16_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] ext;

    always_comb begin
        ext = '0;
        if (sub)
            ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        else
            ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

    assign sum  = ext[WIDTH-1:0];
    // For subtraction the wrapped top bit is the borrow (unsigned a < b+cin).
    assign cout = ext[WIDTH];
    assign ovf  = sub ? ((a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))
                      : ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]));

endmodule

// File: rtl/alu16.sv
// Registered 16-bit ALU: combinational opcode mux feeding one register
// stage holding Y and the status flags, with asynchronous active-low clear.
module alu16
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       aluop,
    output logic [WIDTH-1:0] Y,
    output logic             c_flag,
    output logic             z_flag,
    output logic             n_flag,
    output logic             v_flag,
    output logic             lt,
    output logic             eq
);

    logic [WIDTH-1:0] as_b;
    logic             as_cin;
    logic             as_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             as_ovf;

    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] zn_src;
    logic             c_next;
    logic             v_next;

    alu16_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (A),
        .b    (as_b),
        .cin  (as_cin),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout),
        .ovf  (as_ovf)
    );

    // INC/DEC reuse the adder with b=0 and cin=1.
    always_comb begin
        as_b   = B;
        as_cin = 1'b0;
        as_sub = 1'b0;
        unique case (aluop)
            OP_INC: begin as_b = '0; as_cin = 1'b1; end
            OP_DEC: begin as_b = '0; as_cin = 1'b1; as_sub = 1'b1; end
            OP_SUB,
            OP_CMP: as_sub = 1'b1;
            OP_ADC: as_cin = c_flag;
            default: ;
        endcase
    end

    always_comb begin
        r_next = A;
        c_next = c_flag;
        v_next = 1'b0;
        unique case (aluop)
            OP_PASSA: r_next = A;
            OP_PASSB: r_next = B;
            OP_INC, OP_DEC, OP_SUB, OP_ADD, OP_ADC: begin
                r_next = as_sum;
                c_next = as_cout;
                v_next = as_ovf;
            end
            OP_SHL: begin r_next = {A[WIDTH-2:0], 1'b0};       c_next = A[WIDTH-1]; end
            OP_SHR: begin r_next = {1'b0, A[WIDTH-1:1]};       c_next = A[0];       end
            OP_ASR: begin r_next = {A[WIDTH-1], A[WIDTH-1:1]}; c_next = A[0];       end
            OP_ROL: begin r_next = {A[WIDTH-2:0], A[WIDTH-1]}; c_next = A[WIDTH-1]; end
            OP_CMP: begin
                r_next = A;
                c_next = as_cout;
                v_next = as_ovf;
            end
            OP_NOT: r_next = ~A;
            OP_AND: r_next = A & B;
            OP_OR:  r_next = A | B;
            OP_XOR: r_next = A ^ B;
            default: ;
        endcase
        zn_src = (aluop == OP_CMP) ? as_sum : r_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Y      <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            n_flag <= 1'b0;
            v_flag <= 1'b0;
            lt     <= 1'b0;
            eq     <= 1'b0;
        end else if (en) begin
            Y      <= r_next;
            c_flag <= c_next;
            z_flag <= (zn_src == '0);
            n_flag <= zn_src[WIDTH-1];
            v_flag <= v_next;
            lt     <= ($signed(A) < $signed(B));
            eq     <= (A == B);
        end
    end

endmodule

// File: tb/tb_alu16.sv
// Directed bench for alu16: hand-computed vectors, flags packed as {c,z,n,v,lt,eq}.
module tb_alu16;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  aluop;
    logic [15:0] Y;
    logic        c_flag, z_flag, n_flag, v_flag, lt, eq;

    int unsigned checks;
    int unsigned failures;

    alu16 #(
        .WIDTH (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .A      (A),
        .B      (B),
        .aluop  (aluop),
        .Y      (Y),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .n_flag (n_flag),
        .v_flag (v_flag),
        .lt     (lt),
        .eq     (eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] y_exp, input logic [5:0] f_exp);
        logic [5:0] f_obs;
        f_obs = {c_flag, z_flag, n_flag, v_flag, lt, eq};
        checks++;
        assert (Y === y_exp) else begin
            failures++;
            $error("FAIL %s Y: observed %h expected %h", tag, Y, y_exp);
        end
        checks++;
        assert (f_obs === f_exp) else begin
            failures++;
            $error("FAIL %s flags{c,z,n,v,lt,eq}: observed %b expected %b", tag, f_obs, f_exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        en    = 1'b1;
        aluop = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        en       = 1'b1;
        A        = '0;
        B        = '0;
        aluop    = '0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A     = 16'($urandom);
            B     = 16'($urandom);
            aluop = 4'($urandom);
        end
        #1;
        check("reset_held", 16'h0000, 6'b000000);

        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        A     = 16'h1234;
        aluop = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_release_en0", 16'h0000, 6'b000000);

        do_op(4'h9, 16'hFFFF, 16'h0001); check("add_wrap",  16'h0000, 6'b110010);
        do_op(4'hF, 16'h0002, 16'h0003); check("adc",       16'h0006, 6'b000010);
        do_op(4'h8, 16'h0003, 16'h0005); check("sub_neg",   16'hFFFE, 6'b101010);
        do_op(4'hA, 16'h0005, 16'h0005); check("cmp_eq",    16'h0005, 6'b010001);
        do_op(4'h9, 16'h7FFF, 16'h0001); check("add_ovf",   16'h8000, 6'b001100);
        do_op(4'hC, 16'hF0F0, 16'h0FF0); check("and",       16'h00F0, 6'b000010);
        do_op(4'h4, 16'h8001, 16'h0000); check("shl",       16'h0002, 6'b100010);
        do_op(4'h6, 16'h8001, 16'h0000); check("asr",       16'hC000, 6'b101010);
        do_op(4'h7, 16'h8001, 16'h0000); check("rol",       16'h0003, 6'b100010);
        do_op(4'h5, 16'h8001, 16'h0000); check("shr",       16'h4000, 6'b100010);
        do_op(4'hE, 16'h1234, 16'h1234); check("xor_ckeep", 16'h0000, 6'b110001);
        do_op(4'h2, 16'hFFFF, 16'h0000); check("inc_wrap",  16'h0000, 6'b110010);
        do_op(4'h3, 16'h0000, 16'h0000); check("dec_wrap",  16'hFFFF, 6'b101001);
        do_op(4'h3, 16'h8000, 16'h0000); check("dec_ovf",   16'h7FFF, 6'b000110);
        do_op(4'h1, 16'h0000, 16'hABCD); check("passb",     16'hABCD, 6'b001000);
        do_op(4'hA, 16'h0003, 16'h0005); check("cmp_lt",    16'h0003, 6'b101010);
        do_op(4'hB, 16'h00FF, 16'h0000); check("not",       16'hFF00, 6'b101000);
        do_op(4'hD, 16'h0F00, 16'h00F0); check("or",        16'h0FF0, 6'b100000);
        do_op(4'h0, 16'h0000, 16'h0000); check("passa",     16'h0000, 6'b110001);
        do_op(4'h0, 16'h1234, 16'h0001); check("passa2",    16'h1234, 6'b100000);

        @(negedge clk);
        en    = 1'b0;
        A     = 16'hFFFF;
        B     = 16'h7FFF;
        aluop = 4'h9;
        @(posedge clk);
        @(negedge clk);
        A     = 16'h0000;
        aluop = 4'h3;
        @(posedge clk);
        #1;
        check("hold_en0", 16'h1234, 6'b100000);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 16'h0000, 6'b000000);
        #1;
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
